// File: rtl/rgb2gray_stream_if.sv
// RGB888 input stream and 8-bit luma output stream bundle
// for rgb2gray_stream; master drives pixels, slave is the converter.
interface rgb2gray_stream_if;
   logic        rgb_valid;
   logic        rgb_sof;
   logic [7:0]  rgb_r;
   logic [7:0]  rgb_g;
   logic [7:0]  rgb_b;
   logic        gray_valid;
   logic [7:0]  gray;
   logic        gray_sof;
   logic        gray_eol;
   logic        frame_done;
   logic [31:0] gray_row;
   logic [31:0] gray_col;
   logic [7:0]  stat_min;
   logic [7:0]  stat_max;

   modport master (
      output rgb_valid, rgb_sof, rgb_r, rgb_g, rgb_b,
      input  gray_valid, gray, gray_sof, gray_eol, frame_done,
      input  gray_row, gray_col, stat_min, stat_max
   );

   modport slave (
      input  rgb_valid, rgb_sof, rgb_r, rgb_g, rgb_b,
      output gray_valid, gray, gray_sof, gray_eol, frame_done,
      output gray_row, gray_col, stat_min, stat_max
   );
endinterface

// File: rtl/rgb2gray_stream.sv
// Two-stage RGB888 -> luma stream converter with row/col tagging.
// Optional frame min/max statistics enabled by defining GRAY_STATS_EN.
module rgb2gray_stream #(
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240
) (
   input logic             clk,
   input logic             rst_n,
   rgb2gray_stream_if.slave bus
);
   localparam logic [31:0] LAST_COL = 32'(IMAGE_WIDTH - 1);
   localparam logic [31:0] LAST_ROW = 32'(IMAGE_HEIGHT - 1);

   logic [31:0] cnt_col, cnt_row;
   logic [31:0] pos_col, pos_row;

   logic        s1_valid, s1_sof, s1_eol, s1_done;
   logic [14:0] p_r;
   logic [15:0] p_g;
   logic [12:0] p_b;
   logic [31:0] s1_row, s1_col;

   logic [16:0] sum;
   logic [7:0]  g_new;

   logic        o_valid, o_sof, o_eol, o_done;
   logic [7:0]  o_gray;
   logic [31:0] o_row, o_col;

   // A start-of-frame pixel is re-tagged as (0,0) regardless of the counters
   always_comb begin
      pos_col = bus.rgb_sof ? '0 : cnt_col;
      pos_row = bus.rgb_sof ? '0 : cnt_row;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_col <= '0;
         cnt_row <= '0;
      end else if (bus.rgb_valid) begin
         if (pos_col == LAST_COL) begin
            cnt_col <= '0;
            cnt_row <= (pos_row == LAST_ROW) ? '0 : pos_row + 32'd1;
         end else begin
            cnt_col <= pos_col + 32'd1;
            cnt_row <= pos_row;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_eol   <= 1'b0;
         s1_done  <= 1'b0;
         p_r      <= '0;
         p_g      <= '0;
         p_b      <= '0;
         s1_row   <= '0;
         s1_col   <= '0;
      end else begin
         s1_valid <= bus.rgb_valid;
         if (bus.rgb_valid) begin
            p_r    <= 15'(bus.rgb_r) * 15'd77;
            p_g    <= 16'(bus.rgb_g) * 16'd150;
            p_b    <= 13'(bus.rgb_b) * 13'd29;
            s1_row <= pos_row;
            s1_col <= pos_col;
            s1_sof <= (pos_row == '0) && (pos_col == '0);
            s1_eol <= (pos_col == LAST_COL);
            s1_done <= (pos_col == LAST_COL) && (pos_row == LAST_ROW);
         end
      end
   end

   // Weights total 256, so the rounded sum >> 8 never exceeds 255
   always_comb begin
      sum   = 17'(p_r) + 17'(p_g) + 17'(p_b) + 17'd128;
      g_new = 8'(sum >> 8);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_sof   <= 1'b0;
         o_eol   <= 1'b0;
         o_done  <= 1'b0;
         o_gray  <= '0;
         o_row   <= '0;
         o_col   <= '0;
      end else begin
         o_valid <= s1_valid;
         o_sof   <= s1_valid & s1_sof;
         o_eol   <= s1_valid & s1_eol;
         o_done  <= s1_valid & s1_done;
         if (s1_valid) begin
            o_gray <= g_new;
            o_row  <= s1_row;
            o_col  <= s1_col;
         end
      end
   end

   assign bus.gray_valid = o_valid;
   assign bus.gray       = o_gray;
   assign bus.gray_sof   = o_sof;
   assign bus.gray_eol   = o_eol;
   assign bus.frame_done = o_done;
   assign bus.gray_row   = o_row;
   assign bus.gray_col   = o_col;

`ifdef GRAY_STATS_EN
   logic [7:0] run_min, run_max;
   logic [7:0] st_min, st_max;

   // Running values cover the pixel being emitted, so the snapshot
   // taken on the frame_done cycle includes the last pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_min <= '0;
         run_max <= '0;
         st_min  <= '0;
         st_max  <= '0;
      end else begin
         if (s1_valid) begin
            if (s1_sof) begin
               run_min <= g_new;
               run_max <= g_new;
            end else begin
               if (g_new < run_min) run_min <= g_new;
               if (g_new > run_max) run_max <= g_new;
            end
         end
         if (o_valid && o_done) begin
            st_min <= run_min;
            st_max <= run_max;
         end
      end
   end

   assign bus.stat_min = st_min;
   assign bus.stat_max = st_max;
`else
   assign bus.stat_min = '0;
   assign bus.stat_max = '0;
`endif
endmodule

// File: tb/tb_rgb2gray_stream.sv
// Scoreboard bench for rgb2gray_stream on a reduced 40x30 frame.
// Define GRAY_STATS_EN for both DUT and bench to check statistics.
module tb_rgb2gray_stream;
   localparam int W = 40;
   localparam int H = 30;

   typedef struct packed {
      logic [7:0]  g;
      logic [31:0] row;
      logic [31:0] col;
      logic        sof;
      logic        eol;
      logic        done;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rgb2gray_stream_if bus();

   rgb2gray_stream #(
      .IMAGE_WIDTH (W),
      .IMAGE_HEIGHT(H)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   int   m_row = 0;
   int   m_col = 0;

   function automatic logic [7:0] gray_of(input logic [7:0] r, g, b);
      int s;
      s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b) + 128;
      return 8'(s >> 8);
   endfunction

   // Drive one input cycle; accepted pixels push their expected output
   task automatic send(input bit v, input bit sof,
                       input logic [7:0] r, g, b, input int eg);
      exp_t e;
      bus.rgb_valid = v;
      bus.rgb_sof   = sof;
      bus.rgb_r     = r;
      bus.rgb_g     = g;
      bus.rgb_b     = b;
      if (v) begin
         if (sof) begin
            m_row = 0;
            m_col = 0;
         end
         e.g    = (eg < 0) ? gray_of(r, g, b) : eg[7:0];
         e.row  = 32'(m_row);
         e.col  = 32'(m_col);
         e.sof  = (m_row == 0) && (m_col == 0);
         e.eol  = (m_col == W - 1);
         e.done = (m_col == W - 1) && (m_row == H - 1);
         q.push_back(e);
         if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end
   endtask

   task automatic test_reset();
      send(0, 0, 8'd0, 8'd0, 8'd0, -1);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.gray_valid, bus.gray, bus.gray_sof, bus.gray_eol,
           bus.frame_done, bus.gray_row, bus.gray_col,
           bus.stat_min, bus.stat_max} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b g=%0d r=%0d c=%0d, required all 0",
                  bus.gray_valid, bus.gray, bus.gray_row, bus.gray_col);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_levels();
      bit         ev[6] = '{0, 0, 1, 1, 1, 0};
      logic [7:0] lv[3] = '{8'd200, 8'd0, 8'd255};
      exp_t e, got;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.gray_valid !== ev[j]) begin
            n_bad++;
            $display("FAIL levels_latency step %0d: valid %b, required %b",
                     j, bus.gray_valid, ev[j]);
         end else if (bus.gray_valid && q.size() != 0) begin
            e = q.pop_front();
            got = {bus.gray, bus.gray_row, bus.gray_col,
                   bus.gray_sof, bus.gray_eol, bus.frame_done};
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL levels_pixel: got %h, required %h", got, e);
            end
         end
         if (j < 3) send(1, 0, lv[j], lv[j], lv[j], int'(lv[j]));
         else       send(0, 0, 8'd0, 8'd0, 8'd0, -1);
      end
   endtask

   task automatic test_primaries();
      bit         ev[6] = '{0, 0, 1, 1, 1, 0};
      logic [7:0] pr[3] = '{8'd255, 8'd0, 8'd0};
      logic [7:0] pg[3] = '{8'd0, 8'd255, 8'd0};
      logic [7:0] pb[3] = '{8'd0, 8'd0, 8'd255};
      int         pe[3] = '{77, 149, 29};
      exp_t e, got;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.gray_valid !== ev[j]) begin
            n_bad++;
            $display("FAIL primaries_latency step %0d: valid %b, required %b",
                     j, bus.gray_valid, ev[j]);
         end else if (bus.gray_valid && q.size() != 0) begin
            e = q.pop_front();
            got = {bus.gray, bus.gray_row, bus.gray_col,
                   bus.gray_sof, bus.gray_eol, bus.frame_done};
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL primaries_pixel: got %h, required %h", got, e);
            end
         end
         if (j < 3) send(1, 0, pr[j], pg[j], pb[j], pe[j]);
         else       send(0, 0, 8'd0, 8'd0, 8'd0, -1);
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL primaries_drain: %0d pending, required 0", q.size());
      end
   endtask

   task automatic test_full_frame();
      exp_t e, got;
      int i = 0, cyc = 0, nv = 0, neol = 0, nsof = 0, ndone = 0;
      while ((i < W * H || q.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (bus.gray_valid) begin
            nv++;
            if (bus.gray_eol)   neol++;
            if (bus.gray_sof)   nsof++;
            if (bus.frame_done) ndone++;
            got = {bus.gray, bus.gray_row, bus.gray_col,
                   bus.gray_sof, bus.gray_eol, bus.frame_done};
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL frame_extra: got %h, required no output", got);
            end else begin
               e = q.pop_front();
               if (got !== e) begin
                  n_bad++;
                  $display("FAIL frame_pixel: got %h, required %h", got, e);
               end
            end
         end
         if (i < W * H && $urandom_range(0, 3) != 0) begin
            send(1, i == 0, 8'($urandom), 8'($urandom), 8'($urandom), -1);
            i++;
         end else begin
            send(0, 0, 8'd0, 8'd0, 8'd0, -1);
         end
      end
      n_cmp++;
      if (q.size() != 0 || i != W * H) begin
         n_bad++;
         $display("FAIL frame_timeout: %0d pending, required 0", q.size());
      end
      n_cmp++;
      if (nv != W * H) begin
         n_bad++;
         $display("FAIL frame_valid_count: %0d, required %0d", nv, W * H);
      end
      n_cmp++;
      if (neol != H) begin
         n_bad++;
         $display("FAIL frame_eol_count: %0d, required %0d", neol, H);
      end
      n_cmp++;
      if (nsof != 1 || ndone != 1) begin
         n_bad++;
         $display("FAIL frame_sof_done_count: sof %0d done %0d, required 1 1",
                  nsof, ndone);
      end
   endtask

   task automatic test_resync();
      exp_t e, got;
      int i = 0, cyc = 0, nsof = 0, ndone = 0;
      while ((i < 1050 || q.size() != 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (bus.gray_valid) begin
            if (bus.gray_sof)   nsof++;
            if (bus.frame_done) ndone++;
            got = {bus.gray, bus.gray_row, bus.gray_col,
                   bus.gray_sof, bus.gray_eol, bus.frame_done};
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL resync_extra: got %h, required no output", got);
            end else begin
               e = q.pop_front();
               if (got !== e) begin
                  n_bad++;
                  $display("FAIL resync_pixel: got %h, required %h", got, e);
               end
            end
         end
         if (i < 1050 && $urandom_range(0, 4) != 0) begin
            send(1, i == 0 || i == 1000,
                 8'($urandom), 8'($urandom), 8'($urandom), -1);
            i++;
         end else begin
            send(0, 0, 8'd0, 8'd0, 8'd0, -1);
         end
      end
      n_cmp++;
      if (q.size() != 0 || nsof != 2 || ndone != 0) begin
         n_bad++;
         $display("FAIL resync_flags: pend %0d sof %0d done %0d, required 0 2 0",
                  q.size(), nsof, ndone);
      end
   endtask

   task automatic test_reset_in_flight();
      exp_t e, got;
      @(negedge clk);
      send(1, 0, 8'd90, 8'd100, 8'd110, -1);
      @(negedge clk);
      send(1, 0, 8'd120, 8'd130, 8'd140, -1);
      rst_n = 1'b0;
      q.delete();
      m_row = 0;
      m_col = 0;
      @(negedge clk);
      n_cmp++;
      if ({bus.gray_valid, bus.gray, bus.gray_sof, bus.gray_eol,
           bus.frame_done, bus.gray_row, bus.gray_col,
           bus.stat_min, bus.stat_max} !== '0) begin
         n_bad++;
         $display("FAIL rif_outputs: got v=%b g=%0d r=%0d c=%0d, required all 0",
                  bus.gray_valid, bus.gray, bus.gray_row, bus.gray_col);
      end
      send(0, 0, 8'd0, 8'd0, 8'd0, -1);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (bus.gray_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rif_ghost: valid %b, required 0", bus.gray_valid);
         end
      end
      send(1, 0, 8'd50, 8'd60, 8'd70, -1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 0) send(0, 0, 8'd0, 8'd0, 8'd0, -1);
         n_cmp++;
         if (bus.gray_valid !== (k == 1)) begin
            n_bad++;
            $display("FAIL rif_latency step %0d: valid %b, required %b",
                     k, bus.gray_valid, k == 1);
         end else if (bus.gray_valid && q.size() != 0) begin
            e = q.pop_front();
            got = {bus.gray, bus.gray_row, bus.gray_col,
                   bus.gray_sof, bus.gray_eol, bus.frame_done};
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL rif_first_pixel: got %h, required %h", got, e);
            end
         end
      end
   endtask

   task automatic test_stats();
      exp_t e, got;
      logic [7:0] emin, emax, v;
      int i = 0, cyc = 0;
      bit chk_next = 0, checked = 0;
`ifdef GRAY_STATS_EN
      emin = 8'd10;
      emax = 8'd250;
`else
      emin = 8'd0;
      emax = 8'd0;
`endif
      while ((i < W * H || q.size() != 0 || chk_next) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (chk_next) begin
            chk_next = 0;
            checked = 1;
            n_cmp++;
            if ({bus.stat_min, bus.stat_max} !== {emin, emax}) begin
               n_bad++;
               $display("FAIL stats_after_done: min %0d max %0d, required %0d %0d",
                        bus.stat_min, bus.stat_max, emin, emax);
            end
         end
         if (bus.gray_valid) begin
            got = {bus.gray, bus.gray_row, bus.gray_col,
                   bus.gray_sof, bus.gray_eol, bus.frame_done};
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL stats_extra: got %h, required no output", got);
            end else begin
               e = q.pop_front();
               if (got !== e) begin
                  n_bad++;
                  $display("FAIL stats_pixel: got %h, required %h", got, e);
               end
            end
            if (bus.frame_done) begin
               chk_next = 1;
               n_cmp++;
               if ({bus.stat_min, bus.stat_max} !== 16'h0) begin
                  n_bad++;
                  $display("FAIL stats_early: min %0d max %0d, required 0 0",
                           bus.stat_min, bus.stat_max);
               end
            end
         end
         if (i < W * H && $urandom_range(0, 3) != 0) begin
            v = 8'(10 + (i % 241));
            send(1, i == 0, v, v, v, int'(v));
            i++;
         end else begin
            send(0, 0, 8'd0, 8'd0, 8'd0, -1);
         end
      end
      n_cmp++;
      if (!checked) begin
         n_bad++;
         $display("FAIL stats_no_done: frame_done not seen, required 1");
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({bus.stat_min, bus.stat_max} !== {emin, emax}) begin
         n_bad++;
         $display("FAIL stats_hold: min %0d max %0d, required %0d %0d",
                  bus.stat_min, bus.stat_max, emin, emax);
      end
   endtask

   initial begin
      test_reset();
      test_levels();
      test_primaries();
      test_full_frame();
      test_resync();
      test_reset_in_flight();
      test_stats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule
